dff_pipe: RTL and testbench
===========================

// Module: dff_pipe
//
// PURPOSE
//   Parametrised successor to the single D flip-flop: a WIDTH-bit, DEPTH-stage
//   register pipeline with a per-stage valid bit, global stall (en), flush and a
//   live occupancy count. Used as a configurable delay/retiming line between
//   datapath blocks, with the bare-DFF case kept as WIDTH=1, DEPTH=1.
//
// PARAMETERS
//   WIDTH      8      data bits per stage (>=1)
//   DEPTH      4      number of register stages = latency in enabled cycles (>=1)
//   RESET_VAL  '0     value loaded into every data stage on reset (WIDTH bits)
//   GATE_DATA  0      1: a stage captures RESET_VAL instead of data when its
//                     incoming valid is 0; 0: data shifts ungated
//
// PORTS
//   clk        in   1                      rising-edge clock
//   reset      in   1                      asynchronous, active-high reset
//   en         in   1                      1 = advance pipeline one stage; 0 = hold
//   flush      in   1                      1 = invalidate all stages at next edge
//   d          in   WIDTH                  input data
//   d_valid    in   1                      input data qualifier
//   q          out  WIDTH                  data of last stage (DEPTH-1)
//   q_valid    out  1                      valid of last stage
//   occupancy  out  $clog2(DEPTH+1)        number of valid stages, 0..DEPTH
//
// BEHAVIOUR
//   - Reset (async assert, sync-safe deassert by system): all data stages =
//     RESET_VAL, all valids = 0, occupancy = 0, q = RESET_VAL, q_valid = 0.
//     Reset asserted mid-operation clears immediately, no clock needed.
//   - Priority per rising edge: reset > flush > en > hold.
//   - en=1, flush=0: stage[0] <= d, vld[0] <= d_valid; stage[i] <= stage[i-1],
//     vld[i] <= vld[i-1] for i=1..DEPTH-1. Data accepted with d_valid=1 appears on
//     q with q_valid=1 after exactly DEPTH enabled edges.
//   - en=0, flush=0: every data and valid register holds; q/q_valid stable.
//     d/d_valid presented during a stall are NOT captured (no backpressure port;
//     upstream must hold or drop).
//   - flush=1 (any en): all vld <= 0, occupancy <= 0; d_valid that cycle dropped.
//     Data registers: hold when GATE_DATA=0, load RESET_VAL when GATE_DATA=1.
//   - GATE_DATA=1: on an enabled shift, a stage whose incoming valid is 0 loads
//     RESET_VAL, so q == RESET_VAL whenever q_valid == 0 after first fill.
//   - occupancy: registered counter, updated only on enabled edges:
//     occ_next = occ + d_valid - q_valid (q_valid = value before the edge).
//     Simultaneous entry and exit -> unchanged. Never exceeds DEPTH, never
//     wraps below 0. Must equal popcount(vld) at all times (asserted in bench).
//   - Outputs are registered; no combinational path from inputs to q/q_valid/
//     occupancy.
//   - DEPTH=1: behaves as a single enabled DFF with valid; occupancy is 1 bit.
//
// STRUCTURE
//   - dff_pipe_pkg: function occ_width(depth) = $clog2(depth+1); shared
//     localparam defaults (DFF_PIPE_WIDTH_DEF=8, DFF_PIPE_DEPTH_DEF=4).
//   - Sub-module dff_stage: one WIDTH-bit data reg + valid reg with async reset,
//     en, clr (valid clear), gate (RESET_VAL load); instantiated DEPTH times by
//     a generate loop; occupancy counter lives in dff_pipe top.
//
// TESTING  (WIDTH=8, DEPTH=4, RESET_VAL=8'h00 unless noted)
//   1 Latency: en=1, drive d=8'hA1..A4 valid on 4 edges -> q=8'hA1,q_valid=1 on
//     4th edge after first; occupancy ramps 1,2,3,4 then holds 4 with continuous flow.
//   2 Stall: fill with A1..A4, en=0 for 3 cycles while d=8'hFF valid -> q,
//     q_valid, occupancy unchanged; on resume, FF never appears on q.
//   3 Flush vs en: occupancy=4, assert flush=1 and en=1 with d_valid=1 same cycle
//     -> next edge q_valid=0, occupancy=0; 4 later edges show no valid output.
//   4 Async reset mid-stream: occupancy=3, pulse reset between clock edges ->
//     q=8'h00, q_valid=0, occupancy=0 before next edge; resume works normally.
//   5 Bubbles: pattern valid,0,valid,0 -> q_valid toggles 1,0,1,0 at DEPTH
//     latency; occupancy stays 2; GATE_DATA=1 run shows q=8'h00 on bubble cycles.
//   6 DEPTH=1,WIDTH=1: d=1 valid, en=1 -> q=1,q_valid=1 next edge; en=0 holds.

Source files
------------

// File: rtl/dff_pipe_pkg.sv
// Shared defaults and sizing helpers for the dff_pipe delay line.
package dff_pipe_pkg;

  localparam int DFF_PIPE_WIDTH_DEF = 8;
  localparam int DFF_PIPE_DEPTH_DEF = 4;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One register stage of the dff_pipe line: data plus valid qualifier.
module dff_stage
  import dff_pipe_pkg::*;
#(
  parameter int              WIDTH     = DFF_PIPE_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             gate_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             d_valid_i,
  output logic [WIDTH-1:0] q_o,
  output logic             q_valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;

  // clr wins over en; gate selects RESET_VAL over the incoming data
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (clr_i) begin
      vld_d = 1'b0;
      if (gate_i) data_d = RESET_VAL;
    end else if (en_i) begin
      vld_d  = d_valid_i;
      data_d = gate_i ? RESET_VAL : d_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VAL;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q_o       = data_q;
  assign q_valid_o = vld_q;

endmodule

// File: rtl/dff_pipe.sv
// WIDTH x DEPTH register pipeline with valids, stall, flush and occupancy.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH     = DFF_PIPE_WIDTH_DEF,
  parameter int               DEPTH     = DFF_PIPE_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               GATE_DATA = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              d,
  input  logic                          d_valid,
  output logic [WIDTH-1:0]              q,
  output logic                          q_valid,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int OW = occ_width(DEPTH);

  logic [WIDTH-1:0] data_w [DEPTH+1];
  logic             vld_w  [DEPTH+1];
  logic             gate_w [DEPTH];

  assign data_w[0] = d;
  assign vld_w[0]  = d_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    assign gate_w[i] = GATE_DATA && (flush || !vld_w[i]);

    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .en_i      (en),
      .clr_i     (flush),
      .gate_i    (gate_w[i]),
      .d_i       (data_w[i]),
      .d_valid_i (vld_w[i]),
      .q_o       (data_w[i+1]),
      .q_valid_o (vld_w[i+1])
    );
  end

  logic [OW-1:0] occ_q, occ_d;

  // entry and exit in the same edge cancel out
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (en) begin
      occ_d = occ_q + OW'(d_valid) - OW'(vld_w[DEPTH]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  assign q         = data_w[DEPTH];
  assign q_valid   = vld_w[DEPTH];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: table vectors, corner sequences and a random run.
module tb_dff_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, flush, dv;
  logic [7:0] d;
  logic [7:0] q_a, q_b;
  logic       qv_a, qv_b;
  logic [2:0] occ_a, occ_b;

  logic en_c, d_c, dv_c, q_c, qv_c, occ_c;

  int checks = 0;
  int failures = 0;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00), .GATE_DATA(1'b0)) u_a (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .d(d),
    .d_valid(dv), .q(q_a), .q_valid(qv_a), .occupancy(occ_a));

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00), .GATE_DATA(1'b1)) u_b (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .d(d),
    .d_valid(dv), .q(q_b), .q_valid(qv_b), .occupancy(occ_b));

  dff_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0), .GATE_DATA(1'b0)) u_c (
    .clk(clk), .reset(reset), .en(en_c), .flush(1'b0), .d(d_c),
    .d_valid(dv_c), .q(q_c), .q_valid(qv_c), .occupancy(occ_c));

  // reference: list of slots, index 3 is the output end
  logic [7:0] m_d0 [4];
  logic [7:0] m_d1 [4];
  logic       m_v  [4];

  function automatic int m_occ();
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(m_v[i]);
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_d0[i] = 8'h00; m_d1[i] = 8'h00; m_v[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic e, input logic f,
                            input logic [7:0] din, input logic vin);
    if (f) begin
      for (int i = 0; i < 4; i++) begin
        m_v[i] = 1'b0; m_d1[i] = 8'h00;
      end
    end else if (e) begin
      for (int i = 3; i > 0; i--) begin
        m_d0[i] = m_d0[i-1];
        m_d1[i] = m_v[i-1] ? m_d1[i-1] : 8'h00;
        m_v[i]  = m_v[i-1];
      end
      m_d0[0] = din;
      m_d1[0] = vin ? din : 8'h00;
      m_v[0]  = vin;
    end
  endtask

  task automatic cmp_model();
    chk("a_q", int'(q_a), int'(m_d0[3]));
    chk("a_qv", int'(qv_a), int'(m_v[3]));
    chk("a_occ", int'(occ_a), m_occ());
    chk("b_q", int'(q_b), int'(m_d1[3]));
    chk("b_qv", int'(qv_b), int'(m_v[3]));
    chk("b_occ", int'(occ_b), m_occ());
    if (!qv_b) chk("b_bubble_zero", int'(q_b), 0);
  endtask

  task automatic step(input logic e, input logic f,
                      input logic [7:0] din, input logic vin);
    en = e; flush = f; d = din; dv = vin;
    @(posedge clk);
    model_edge(e, f, din, vin);
    #1;
    cmp_model();
  endtask

  typedef struct {
    logic       en;
    logic       fl;
    logic [7:0] d;
    logic       dv;
    logic [7:0] q;
    logic       qv;
    logic [2:0] occ;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #1ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1, 0, 8'hA1, 1, 8'h00, 0, 1};
    tbl[1]  = '{1, 0, 8'hA2, 1, 8'h00, 0, 2};
    tbl[2]  = '{1, 0, 8'hA3, 1, 8'h00, 0, 3};
    tbl[3]  = '{1, 0, 8'hA4, 1, 8'hA1, 1, 4};
    tbl[4]  = '{1, 0, 8'hB1, 1, 8'hA2, 1, 4};
    tbl[5]  = '{0, 0, 8'hFF, 1, 8'hA2, 1, 4};
    tbl[6]  = '{0, 0, 8'hFF, 1, 8'hA2, 1, 4};
    tbl[7]  = '{0, 0, 8'hFF, 1, 8'hA2, 1, 4};
    tbl[8]  = '{1, 0, 8'hB2, 1, 8'hA3, 1, 4};
    tbl[9]  = '{1, 0, 8'hB3, 1, 8'hA4, 1, 4};
    tbl[10] = '{1, 0, 8'hB4, 1, 8'hB1, 1, 4};
    tbl[11] = '{1, 1, 8'hC1, 1, 8'hB1, 0, 0};
    tbl[12] = '{1, 0, 8'h00, 0, 8'hB2, 0, 0};
    tbl[13] = '{1, 0, 8'h00, 0, 8'hB3, 0, 0};
    tbl[14] = '{1, 0, 8'h00, 0, 8'hB4, 0, 0};
    tbl[15] = '{1, 0, 8'h00, 0, 8'h00, 0, 0};

    reset = 1'b1; en = 0; flush = 0; d = 0; dv = 0;
    en_c = 0; d_c = 0; dv_c = 0;
    model_reset();
    #1;
    chk("rst_q", int'(q_a), 0);
    chk("rst_qv", int'(qv_a), 0);
    chk("rst_occ", int'(occ_a), 0);
    chk("rst_c_q", int'(q_c), 0);
    chk("rst_c_occ", int'(occ_c), 0);
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;

    // latency, stall, flush-over-enable
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].en, tbl[i].fl, tbl[i].d, tbl[i].dv);
      chk($sformatf("tbl%0d_q", i), int'(q_a), int'(tbl[i].q));
      chk($sformatf("tbl%0d_qv", i), int'(qv_a), int'(tbl[i].qv));
      chk($sformatf("tbl%0d_occ", i), int'(occ_a), int'(tbl[i].occ));
    end

    // async reset between edges with occupancy 3
    step(1, 0, 8'h11, 1);
    step(1, 0, 8'h12, 1);
    step(1, 0, 8'h13, 1);
    chk("pre_rst_occ", int'(occ_a), 3);
    #2 reset = 1'b1;
    #1;
    chk("arst_q", int'(q_a), 0);
    chk("arst_qv", int'(qv_a), 0);
    chk("arst_occ", int'(occ_a), 0);
    chk("arst_b_occ", int'(occ_b), 0);
    reset = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 4; i++) step(1, 0, 8'h20 + 8'(i), 1);
    chk("resume_q", int'(q_a), 32'h20);
    chk("resume_qv", int'(qv_a), 1);

    // drain, then alternating bubbles
    for (int i = 0; i < 4; i++) step(1, 0, 8'h00, 0);
    for (int k = 1; k <= 12; k++) begin
      logic [7:0] r;
      r = 8'($urandom_range(1, 255));
      step(1, 0, r, k[0]);
      if (k >= 4) begin
        chk("bub_qv", int'(qv_a), int'(k % 2 == 0));
        chk("bub_b_qv", int'(qv_b), int'(k % 2 == 0));
      end
      if (k >= 3) chk("bub_occ", int'(occ_a), 2);
    end

    // randomized run
    for (int n = 0; n < 400; n++) begin
      step(logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 19) == 0),
           8'($urandom), logic'($urandom_range(0, 1)));
    end

    // single-bit single-stage instance
    en_c = 1; d_c = 1; dv_c = 1;
    @(posedge clk); #1;
    chk("c_q", int'(q_c), 1);
    chk("c_qv", int'(qv_c), 1);
    chk("c_occ", int'(occ_c), 1);
    en_c = 0; d_c = 0; dv_c = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("c_hold_q", int'(q_c), 1);
    chk("c_hold_qv", int'(qv_c), 1);
    chk("c_hold_occ", int'(occ_c), 1);
    en_c = 1;
    @(posedge clk); #1;
    chk("c_drain_q", int'(q_c), 0);
    chk("c_drain_qv", int'(qv_c), 0);
    chk("c_drain_occ", int'(occ_c), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
